// File: rtl/dmadd_cmd_seq.sv
// dmadd_cmd_seq
//   Byte-command sequencer feeding the delta-MADD / min-max search core.
//   Decodes INIT / LOAD / RUN / CLEAR commands taken over a valid/ready
//   handshake into the core's control pins. RUN drives the core for n+1 cycles,
//   lets it settle, and then captures its 12-bit result with a one-cycle strobe.
//
//   Optional build macro: SEQ_ERR_EN
//     defined   : LOAD_WAIT times out after TIMEOUT_CYC idle cycles. A timeout
//                 or a dropped illegal payload sets the sticky err flag. A
//                 CLEAR command or rst_n clears err.
//     undefined : LOAD_WAIT waits forever, illegal payloads are dropped
//                 silently, and err is tied low.
//
//   All control outputs are registered. The next-state logic computes the
//   values for the state being entered, so each output lines up with its state.
module dmadd_cmd_seq #(
    parameter int         SETTLE_CYC  = 2,
    parameter logic [1:0] IDLE_INSN   = 2'b11,
    parameter int         TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  cmd_byte,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [3:0]  dm_index,
    output logic [3:0]  dm_data,
    output logic [1:0]  dm_insn,
    output logic        dm_load,
    output logic        dm_run,
    output logic        dm_rst_n,
    input  logic [11:0] dm_out,
    output logic [11:0] result,
    output logic        result_valid,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_INIT       = 3'd1,
        ST_LOAD_WAIT  = 3'd2,
        ST_LOAD_PULSE = 3'd3,
        ST_RUN        = 3'd4,
        ST_SETTLE     = 3'd5,
        ST_CAPTURE    = 3'd6,
        ST_CLEAR      = 3'd7
    } state_t;

    // The settle counter counts up from 0 and stops at SETTLE_CYC-1.
    localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYC - 1);

    state_t      state_r, state_s;
    logic [1:0]  kk_r, kk_s;
    logic [3:0]  run_cnt_r, run_cnt_s;
    logic [2:0]  settle_cnt_r, settle_cnt_s;
    logic [3:0]  index_r, index_s;
    logic [3:0]  data_r, data_s;
    logic [1:0]  insn_r, insn_s;
    logic        load_r, load_s;
    logic        run_r, run_s;
    logic        clear_r, clear_s;
    logic        ready_r, ready_s;
    logic        busy_r, busy_s;
    logic        rvalid_r, rvalid_s;
    logic [11:0] result_r, result_s;
    logic        accept_s;

`ifdef SEQ_ERR_EN
    // The LOAD_WAIT timeout counter counts up from 0 and gives up at TIMEOUT_CYC-1.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0]  to_cnt_r, to_cnt_s;
    logic        err_r, err_s;
`endif

    assign accept_s = cmd_valid & ready_r;

    // Next-state decode and next values of all registered outputs
    always_comb begin
        state_s      = state_r;
        kk_s         = kk_r;
        run_cnt_s    = run_cnt_r;
        settle_cnt_s = settle_cnt_r;
        index_s      = index_r;
        data_s       = data_r;
        insn_s       = IDLE_INSN;
        load_s       = 1'b0;
        run_s        = 1'b0;
        clear_s      = 1'b0;
        rvalid_s     = 1'b0;
        result_s     = result_r;
`ifdef SEQ_ERR_EN
        to_cnt_s     = to_cnt_r;
        err_s        = err_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (cmd_byte[7:6])
                        2'b00: begin
                            // INIT: only MIN (00) and MAX/MADD start (01) are legal
                            if (cmd_byte[1] == 1'b0) begin
                                state_s = ST_INIT;
                                insn_s  = cmd_byte[1:0];
                            end else begin
`ifdef SEQ_ERR_EN
                                err_s = 1'b1;
`endif
                            end
                        end
                        2'b01: begin
                            if (cmd_byte[1:0] != 2'b11) begin
                                kk_s    = cmd_byte[1:0];
                                state_s = ST_LOAD_WAIT;
`ifdef SEQ_ERR_EN
                                to_cnt_s = 8'd0;
`endif
                            end else begin
`ifdef SEQ_ERR_EN
                                err_s = 1'b1;
`endif
                            end
                        end
                        2'b10: begin
                            if (cmd_byte[5:4] != 2'b11) begin
                                kk_s      = cmd_byte[5:4];
                                run_cnt_s = cmd_byte[3:0];
                                state_s   = ST_RUN;
                                run_s     = 1'b1;
                                insn_s    = cmd_byte[5:4];
                            end else begin
`ifdef SEQ_ERR_EN
                                err_s = 1'b1;
`endif
                            end
                        end
                        default: begin
                            // CLEAR: pulse core reset and clear the held result
                            state_s  = ST_CLEAR;
                            clear_s  = 1'b1;
                            result_s = 12'd0;
`ifdef SEQ_ERR_EN
                            err_s = 1'b0;
`endif
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD_WAIT: begin
                if (accept_s) begin
                    index_s = cmd_byte[7:4];
                    data_s  = cmd_byte[3:0];
                    insn_s  = kk_r;
                    load_s  = 1'b1;
                    state_s = ST_LOAD_PULSE;
                end else begin
`ifdef SEQ_ERR_EN
                    if (to_cnt_r == TO_LAST) begin
                        state_s = ST_IDLE;
                        err_s   = 1'b1;
                    end else begin
                        to_cnt_s = to_cnt_r + 8'd1;
                    end
`else
                    state_s = ST_LOAD_WAIT;
`endif
                end
            end
            ST_RUN: begin
                if (run_cnt_r == 4'd0) begin
                    state_s      = ST_SETTLE;
                    settle_cnt_s = 3'd0;
                end else begin
                    run_cnt_s = run_cnt_r - 4'd1;
                    run_s     = 1'b1;
                    insn_s    = kk_r;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_r == SETTLE_LAST) begin
                    state_s  = ST_CAPTURE;
                    rvalid_s = 1'b1;
                    result_s = dm_out;
                end else begin
                    settle_cnt_s = settle_cnt_r + 3'd1;
                end
            end
            ST_INIT:       state_s = ST_IDLE;
            ST_LOAD_PULSE: state_s = ST_IDLE;
            ST_CAPTURE:    state_s = ST_IDLE;
            ST_CLEAR:      state_s = ST_IDLE;
            default:       state_s = ST_IDLE;
        endcase
        ready_s = (state_s == ST_IDLE) || (state_s == ST_LOAD_WAIT);
        busy_s  = ~ready_s;
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            kk_r         <= 2'b00;
            run_cnt_r    <= 4'd0;
            settle_cnt_r <= 3'd0;
            index_r      <= 4'd0;
            data_r       <= 4'd0;
            insn_r       <= IDLE_INSN;
            load_r       <= 1'b0;
            run_r        <= 1'b0;
            clear_r      <= 1'b0;
            ready_r      <= 1'b0;
            busy_r       <= 1'b0;
            rvalid_r     <= 1'b0;
            result_r     <= 12'd0;
`ifdef SEQ_ERR_EN
            to_cnt_r     <= 8'd0;
            err_r        <= 1'b0;
`endif
        end else begin
            state_r      <= state_s;
            kk_r         <= kk_s;
            run_cnt_r    <= run_cnt_s;
            settle_cnt_r <= settle_cnt_s;
            index_r      <= index_s;
            data_r       <= data_s;
            insn_r       <= insn_s;
            load_r       <= load_s;
            run_r        <= run_s;
            clear_r      <= clear_s;
            ready_r      <= ready_s;
            busy_r       <= busy_s;
            rvalid_r     <= rvalid_s;
            result_r     <= result_s;
`ifdef SEQ_ERR_EN
            to_cnt_r     <= to_cnt_s;
            err_r        <= err_s;
`endif
        end
    end

    assign cmd_ready    = ready_r;
    assign dm_index     = index_r;
    assign dm_data      = data_r;
    assign dm_insn      = insn_r;
    assign dm_load      = load_r;
    assign dm_run       = run_r;
    // Core reset follows the system reset and is also pulsed by CLEAR.
    assign dm_rst_n     = rst_n & ~clear_r;
    assign result       = result_r;
    assign result_valid = rvalid_r;
    assign busy         = busy_r;
`ifdef SEQ_ERR_EN
    assign err          = err_r;
`else
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_dmadd_cmd_seq.sv
// Testbench for dmadd_cmd_seq: a randomized command stream, a command-level
// reference model that queues the expected pin events, and an independent
// monitor that pops and compares each event as the DUT shows it.
module tb_dmadd_cmd_seq;

    localparam int         SETTLE_CYC = 2;
    localparam logic [1:0] IDLE_INSN  = 2'b11;
`ifdef SEQ_ERR_EN
    localparam int TIMEOUT_CYC = 8;
    localparam bit ERR_EN      = 1'b1;
`else
    localparam int TIMEOUT_CYC = 255;
    localparam bit ERR_EN      = 1'b0;
`endif

    localparam int K_INIT = 0, K_LOAD = 1, K_RUN = 2, K_RES = 3, K_CLR = 4;

    typedef struct {
        int kind;
        int a;
        int b;
        int c;
        int at;
    } txn_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  cmd_byte;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  dm_index;
    logic [3:0]  dm_data;
    logic [1:0]  dm_insn;
    logic        dm_load;
    logic        dm_run;
    logic        dm_rst_n;
    logic [11:0] dm_out;
    logic [11:0] result;
    logic        result_valid;
    logic        busy;
    logic        err;

    dmadd_cmd_seq #(
        .SETTLE_CYC  (SETTLE_CYC),
        .IDLE_INSN   (IDLE_INSN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_byte     (cmd_byte),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .dm_index     (dm_index),
        .dm_data      (dm_data),
        .dm_insn      (dm_insn),
        .dm_load      (dm_load),
        .dm_run       (dm_run),
        .dm_rst_n     (dm_rst_n),
        .dm_out       (dm_out),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_vec = 0;
    int   n_bad = 0;
    txn_t exp_q[$];
    string kname[5] = '{"INIT", "LOAD", "RUN", "RESULT", "CLEAR"};

    // reference-model state (command level)
    bit          ld_pending = 1'b0;
    logic [1:0]  ld_kk      = 2'b00;
    bit          err_exp    = 1'b0;
    logic [11:0] res_exp    = 12'd0;

    // monitor-private state
    bit         in_run    = 1'b0;
    int         run_len   = 0;
    int         run_start = 0;
    logic [1:0] run_insn  = 2'b00;
    logic [3:0] hold_idx  = 4'd0;
    logic [3:0] hold_dat  = 4'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int kind, input int a, input int b, input int c, input int at);
        txn_t t;
        t.kind = kind; t.a = a; t.b = b; t.c = c; t.at = at;
        exp_q.push_back(t);
    endtask

    // Compare one observed pin event against the oldest expected one.
    task automatic obs(input int kind, input int a, input int b, input int c, input int at);
        txn_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_%s: got a=%0d b=%0d c=%0d at cycle %0d, required no event",
                     kname[kind], a, b, c, at);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.a != a || e.b != b || e.c != c || e.at != at) begin
                n_bad++;
                $display("FAIL event_%s: got %s a=%0d b=%0d c=%0d cyc=%0d, required %s a=%0d b=%0d c=%0d cyc=%0d",
                         kname[e.kind], kname[kind], a, b, c, at,
                         kname[e.kind], e.a, e.b, e.c, e.at);
            end
            if (e.kind == K_LOAD) begin
                hold_idx = 4'(e.b);
                hold_dat = 4'(e.c);
            end
        end
    endtask

    // Reference model: one accepted byte -> expected events; returns cmd_ready in the next cycle.
    task automatic model(input logic [7:0] b, input int at, output bit rdy_after);
        int n;
        rdy_after = 1'b1;
        if (ld_pending) begin
            push(K_LOAD, int'(ld_kk), int'(b[7:4]), int'(b[3:0]), at);
            ld_pending = 1'b0;
            rdy_after  = 1'b0;
        end else begin
            case (b[7:6])
                2'b00: begin
                    if (b[1:0] == 2'b00 || b[1:0] == 2'b01) begin
                        push(K_INIT, int'(b[1:0]), 0, 0, at);
                        rdy_after = 1'b0;
                    end else begin
                        err_exp = err_exp | ERR_EN;
                    end
                end
                2'b01: begin
                    if (b[1:0] != 2'b11) begin
                        ld_pending = 1'b1;
                        ld_kk      = b[1:0];
                    end else begin
                        err_exp = err_exp | ERR_EN;
                    end
                end
                2'b10: begin
                    if (b[5:4] != 2'b11) begin
                        n = int'(b[3:0]) + 1;
                        push(K_RUN, int'(b[5:4]), n, 0, at);
                        push(K_RES, int'(dm_out), 0, 0, at + n + SETTLE_CYC);
                        res_exp   = dm_out;
                        rdy_after = 1'b0;
                    end else begin
                        err_exp = err_exp | ERR_EN;
                    end
                end
                default: begin
                    push(K_CLR, 0, 0, 0, at);
                    res_exp   = 12'd0;
                    err_exp   = 1'b0;
                    rdy_after = 1'b0;
                end
            endcase
        end
    endtask

    // Offer one byte after 'gap' idle cycles, holding it until accepted.
    task automatic send(input logic [7:0] b, input int gap);
        bit rdy, acc, rdy_after;
        int guard;
        repeat (gap) @(posedge clk);
        #1;
        cmd_byte  = b;
        cmd_valid = 1'b1;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 100) begin
            rdy = cmd_ready;
            @(posedge clk);
            acc = rdy;
            #1;
            guard++;
        end
        cmd_valid = 1'b0;
        cmd_byte  = 8'($urandom);
        if (!acc) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            model(b, cyc, rdy_after);
            @(negedge clk);
            check("ready_action_cycle", 32'(cmd_ready), 32'(rdy_after));
            check("busy_action_cycle", 32'(busy), 32'(!rdy_after));
            guard = 0;
            while (!cmd_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            check("ready_return", 32'(cmd_ready), 32'd1);
            check("err", 32'(err), 32'(err_exp));
            check("result_hold", 32'(result), 32'(res_exp));
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_index"}, 32'(dm_index), 32'd0);
        check({tag, "_data"}, 32'(dm_data), 32'd0);
        check({tag, "_insn"}, 32'(dm_insn), 32'(IDLE_INSN));
        check({tag, "_load"}, 32'(dm_load), 32'd0);
        check({tag, "_run"}, 32'(dm_run), 32'd0);
        check({tag, "_dm_rst_n"}, 32'(dm_rst_n), 32'd0);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_result_valid"}, 32'(result_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    endtask

    // Monitor: turn pin activity into events and score them against the queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_run   = 1'b0;
            hold_idx = 4'd0;
            hold_dat = 4'd0;
        end else begin
            if (dm_load) begin
                obs(K_LOAD, int'(dm_insn), int'(dm_index), int'(dm_data), cyc);
            end else begin
                check("index_data_hold", 32'({dm_index, dm_data}), 32'({hold_idx, hold_dat}));
                if (dm_run) begin
                    if (!in_run) begin
                        in_run    = 1'b1;
                        run_len   = 0;
                        run_start = cyc;
                        run_insn  = dm_insn;
                    end
                    if (dm_insn != run_insn) check("run_insn_stable", 32'(dm_insn), 32'(run_insn));
                    run_len++;
                end else begin
                    if (in_run) begin
                        in_run = 1'b0;
                        obs(K_RUN, int'(run_insn), run_len, 0, run_start);
                    end
                    if (dm_insn != IDLE_INSN) obs(K_INIT, int'(dm_insn), 0, 0, cyc);
                end
            end
            if (!dm_rst_n) obs(K_CLR, 0, 0, 0, cyc);
            if (result_valid) obs(K_RES, int'(result), 0, 0, cyc);
        end
    end

    initial begin
        logic [7:0] b;
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        cmd_byte  = 8'h00;
        dm_out    = 12'd0;
        #1 rst_n = 1'b0;
        #2 reset_checks("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_before_edge", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("ready_after_edge", 32'(cmd_ready), 32'd1);

        // MIN search sequence
        send(8'hC0, 0);
        send(8'h00, 0);
        send(8'h40, 0);
        send(8'h50, 0);
        dm_out = 12'd5;
        send(8'h8F, 0);
        check("min_result", 32'(result), 32'd5);

        // illegal INIT payload
        send(8'h02, 1);

        // handshake stall between the two LOAD bytes
        send(8'h41, 0);
        send(8'hA3, 10);

        // back-to-back INIT and a one-cycle RUN
        dm_out = 12'hABC;
        send(8'h01, 0);
        send(8'h90, 0);

        // illegal LOAD and RUN kk
        send(8'h43, 0);
        send(8'hB5, 2);
        send(8'hC0, 0);

`ifdef SEQ_ERR_EN
        // LOAD timeout: LOAD_WAIT lasts TIMEOUT_CYC cycles, then IDLE with err set
        send(8'h40, 0);
        repeat (TIMEOUT_CYC - 2) @(negedge clk);
        check("timeout_still_waiting_err", 32'(err), 32'd0);
        check("timeout_still_waiting_ready", 32'(cmd_ready), 32'd1);
        repeat (2) @(negedge clk);
        ld_pending = 1'b0;
        err_exp    = 1'b1;
        check("timeout_err", 32'(err), 32'd1);
        check("timeout_busy", 32'(busy), 32'd0);
        send(8'hC0, 1);
`endif

        // randomized command stream
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 3))
                0: b = {2'b00, 4'($urandom), 2'($urandom)};
                1: b = {2'b01, 4'($urandom), 2'($urandom)};
                2: b = {2'b10, 2'($urandom), 4'($urandom)};
                default: b = ($urandom_range(0, 3) == 0) ? 8'hC0 : 8'($urandom);
            endcase
            dm_out = 12'($urandom);
            send(b, $urandom_range(0, 2));
        end
        if (ld_pending) send(8'($urandom), 0);

        // asynchronous reset in the middle of a RUN
        dm_out = 12'h3AB;
        @(posedge clk);
        #1;
        cmd_byte  = 8'h8F;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 check("run_before_reset", 32'(dm_run), 32'd1);
        rst_n = 1'b0;
        #1 reset_checks("async");
        exp_q.delete();
        ld_pending = 1'b0;
        err_exp    = 1'b0;
        res_exp    = 12'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("rel_ready_before_edge", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("rel_ready_after_edge", 32'(cmd_ready), 32'd1);
        dm_out = 12'h123;
        send(8'h9F, 0);
        send(8'hC0, 0);

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dmadd_cmd_seq.md
Name: dmadd_cmd_seq

Overview:
- Command sequencer directly upstream of the delta-MADD / min-max search core.
- Accepts a byte-wide command stream over a valid/ready handshake and decodes it into the core's control pins (index, data, insn, load, run, core reset).
- Runs the core for a commanded number of cycles, then captures its 12-bit result and presents it with a one-cycle valid strobe.

Parameters:
- SETTLE_CYC, 2, idle cycles between the last run cycle and result capture (1..7).
- IDLE_INSN, 2'b11, insn code driven whenever load=0 and run=0 and no INIT is issued; the core treats it as no-op.
- TIMEOUT_CYC, 255, max wait in cycles for the second byte of LOAD; used only with SEQ_ERR_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_byte  in  8  command byte
- cmd_valid  in  1  cmd_byte is valid
- cmd_ready  out  1  sequencer can accept a byte
- dm_index  out  4  core index
- dm_data  out  4  core data
- dm_insn  out  2  core insn
- dm_load  out  1  core load
- dm_run  out  1  core run
- dm_rst_n  out  1  core reset, active-low; combinational rst_n AND NOT clear_pulse
- dm_out  in  12  core result
- result  out  12  last captured result
- result_valid  out  1  one-cycle pulse when result updates
- busy  out  1  high in any state except IDLE and LOAD_WAIT
- err  out  1  sticky error; tied 0 without SEQ_ERR_EN

Behaviour:
- Reset, async, while rst_n=0:
  - state=IDLE; dm_index=0, dm_data=0, dm_insn=IDLE_INSN, dm_load=0, dm_run=0.
  - result=0, result_valid=0, err=0, busy=0, cmd_ready=0.
  - cmd_ready rises on the first clk edge after release.
- Byte accept: cmd_valid && cmd_ready at a posedge. cmd_ready=1 only in IDLE and LOAD_WAIT.
- Command decode in IDLE, on cmd_byte[7:6]:
  - 00 INIT. Next cycle drives a one-cycle INIT state with insn=cmd_byte[1:0], load=0, run=0. The payload must be 00 (MIN) or 01 (MAX/MADD start). A payload of 1x is dropped with no pins driven.
  - 01 LOAD. Latches kk=cmd_byte[1:0], then goes to LOAD_WAIT. The second accepted byte gives index=[7:4] and data=[3:0]. The next cycle is LOAD_PULSE: load=1, insn=kk, index and data driven for exactly 1 cycle. kk=11 is dropped when the first byte is accepted, and the block stays in IDLE.
  - 10 RUN. kk=[5:4], n=[3:0]. RUN state lasts n+1 cycles (1..16) with run=1 and insn=kk. Then SETTLE for SETTLE_CYC cycles (run=0, insn=IDLE_INSN). Then CAPTURE: result<=dm_out, result_valid=1 for 1 cycle, then IDLE. kk=11 is dropped.
  - 11 CLEAR. One cycle with clear_pulse=1, so dm_rst_n=0; result<=0 in the same cycle; then IDLE.
- Output rules:
  - dm_index and dm_data hold their last LOAD values outside LOAD_PULSE.
  - dm_insn=IDLE_INSN in IDLE, LOAD_WAIT, SETTLE, CAPTURE and CLEAR.
- Timing:
  - INIT, CLEAR and LOAD_PULSE each occupy exactly the cycle after acceptance.
  - Back-to-back commands: throughput is 1 command per 2 cycles minimum, because the action cycle has cmd_ready=0.
- cmd_valid is ignored while cmd_ready=0. No byte is lost if the upstream holds it.
- result holds between captures. result_valid never asserts outside CAPTURE.
- Counters wrap-free: the run counter is 4 bits and counts down to 0; the settle counter is 3 bits.

Optional Feature:
- Macro SEQ_ERR_EN.
- Enabled:
  - LOAD_WAIT counts cycles. Reaching TIMEOUT_CYC without a byte returns to IDLE with no load pulse and sets err.
  - Any dropped illegal payload also sets err.
  - err clears only on rst_n=0 or a CLEAR command.
- Disabled:
  - LOAD_WAIT waits indefinitely.
  - Illegal payloads are dropped silently.
  - err constant 0.

Test Plan:
- Reset: hold rst_n=0 mid-RUN with dm_run=1 -> all outputs at reset values immediately, without a clock edge; dm_rst_n=0; cmd_ready=1 one edge after release.
- MIN search with core attached: CLEAR 0xC0, INIT 0x00, LOAD 0x40 + 0x50, RUN 0x8F -> dm_load pulses 1 cycle with index=5; dm_run high exactly 16 cycles; result_valid pulses SETTLE_CYC+16 cycles after RUN is accepted; result=12'd5.
- Illegal INIT 0x02 -> no pin activity, state stays IDLE; err=1 with SEQ_ERR_EN, else err=0.
- Handshake stall: present 0x41 with cmd_valid held high, then drop cmd_valid for 10 cycles before 0xA3 -> LOAD_PULSE shows insn=01, index=10, data=3, exactly once.
- LOAD timeout (SEQ_ERR_EN, TIMEOUT_CYC=8): 0x40 then silence -> IDLE after 8 cycles, dm_load never asserts, err=1; a following CLEAR clears err.
- Back-to-back: INIT 0x01 immediately followed by RUN 0x90 (insn 01, 1 cycle) -> cmd_ready low in the INIT cycle; dm_run high exactly 1 cycle; result_valid pulses exactly once.
